seg_alt_sequencer: RTL and testbench

- Control stage directly upstream of the 7-bit seven-segment 2-to-1 display mux.
- Generates that mux's select line: hold pattern A (select=0), hold pattern B (select=1), alternate continuously, or alternate for a fixed burst then return to A.
- Drives "flash between two messages" effects, e.g. score/time or PASS/FAIL, on the board display.
- Timing comes from an internal prescaler counter, so the mux itself stays purely combinational.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_prescaler.sv | 38 +++
 rtl/seg_alt_sequencer.sv | 140 ++++++++++++++
 tb/tb_seg_alt_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared encodings for the seven-segment alternation control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: mode encodings, sequencer state encoding, default half-period
// for a 50 MHz board clock.
package seg_pkg;

  // Select-line mode requested by the display controller.
  localparam logic [1:0] MODE_HOLD_A = 2'b00;
  localparam logic [1:0] MODE_HOLD_B = 2'b01;
  localparam logic [1:0] MODE_ALT    = 2'b10;
  localparam logic [1:0] MODE_BURST  = 2'b11;

  // 0.5 s per pattern at 50 MHz.
  localparam int DEFAULT_HALF_PERIOD = 25000000;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHOW_A = 2'b01,
    SHOW_B = 2'b10
  } seg_state_t;

endpackage

// File: rtl/seg_prescaler.sv
// Free-running modulo-PERIOD counter with clear, enable and terminal-count pulse.
// Latency: tc is combinational from the current count; the count wraps on the next edge.
// Backpressure: none; en=0 freezes the count, clr wins over en.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear to zero (overrides en)
//   en       : advance the count this cycle
//   tc       : high while en=1 and count == PERIOD-1 (the wrap cycle)
//   cnt      : current count value
module seg_prescaler #(
  parameter int CNT_W  = 26,
  parameter int PERIOD = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic             tc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  assign tc = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_alt_sequencer.sv
// Generates the select line of the 7-segment 2:1 display mux: hold A, hold B,
// alternate continuously, or alternate for a fixed burst then rest on A.
// Latency: all outputs registered; mode->select in hold modes is 1 cycle.
// Backpressure: none; start while busy is ignored. Optional pause input
// (macro SEG_ALT_PAUSE_EN) freezes the half-period timer while busy.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : one-cycle launch pulse, honoured only in IDLE with mode[1]=1
//   mode     : 00 hold A, 01 hold B, 10 alternate, 11 burst
//   pause    : (SEG_ALT_PAUSE_EN only) freeze the timer while busy
//   select   : mux select, 0 = pattern A, 1 = pattern B
//   busy     : alternating (SHOW_A / SHOW_B)
//   done     : one-cycle pulse when a burst run finishes
//   tick     : one-cycle pulse per half-period boundary while alternating
module seg_alt_sequencer
  import seg_pkg::*;
#(
  parameter int CNT_W       = 26,
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
  parameter int NUM_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
`ifdef SEG_ALT_PAUSE_EN
  input  logic       pause,
`endif
  output logic       select,
  output logic       busy,
  output logic       done,
  output logic       tick
);

  localparam int TC_W = $clog2(NUM_TOGGLES + 1);
  localparam logic [TC_W-1:0] TGL_MAX = TC_W'(NUM_TOGGLES);

  seg_state_t      state, state_n;
  logic            select_n, busy_n, done_n, tick_n;
  logic [TC_W-1:0] tgl_cnt, tgl_cnt_n, tgl_inc;

  logic             pause_act;
  logic             psc_clr, psc_en, psc_tc;
  logic [CNT_W-1:0] psc_cnt;

`ifdef SEG_ALT_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  // Timer only runs while alternating; it is held at zero in IDLE so a
  // launch always starts a full half-period, and an abort clears it.
  assign psc_clr = (state == IDLE) || !mode[1];
  assign psc_en  = (state != IDLE) && mode[1] && !pause_act;

  seg_prescaler #(
    .CNT_W  (CNT_W),
    .PERIOD (HALF_PERIOD)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (psc_clr),
    .en  (psc_en),
    .tc  (psc_tc),
    .cnt (psc_cnt)
  );

  // Saturating toggle count: continuous runs can last indefinitely, and a
  // later switch to burst must still see "already at the limit".
  assign tgl_inc = (tgl_cnt == TGL_MAX) ? tgl_cnt : tgl_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      select  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tick    <= 1'b0;
      tgl_cnt <= '0;
    end else begin
      state   <= state_n;
      select  <= select_n;
      busy    <= busy_n;
      done    <= done_n;
      tick    <= tick_n;
      tgl_cnt <= tgl_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    select_n  = select;
    done_n    = 1'b0;
    tick_n    = 1'b0;
    tgl_cnt_n = tgl_cnt;

    case (state)
      IDLE: begin
        tgl_cnt_n = '0;
        if (!mode[1]) begin
          select_n = mode[0];
        end else if (start) begin
          state_n  = SHOW_A;
          select_n = 1'b0;
        end
      end

      SHOW_A, SHOW_B: begin
        if (!mode[1]) begin
          // Abort back to a hold mode: no done pulse.
          state_n   = IDLE;
          select_n  = mode[0];
          tgl_cnt_n = '0;
        end else if (psc_tc) begin
          tick_n = 1'b1;
          if (mode == MODE_BURST && tgl_inc >= TGL_MAX) begin
            // Final burst boundary: rest on A instead of inverting.
            state_n   = IDLE;
            select_n  = 1'b0;
            done_n    = 1'b1;
            tgl_cnt_n = '0;
          end else begin
            state_n   = (state == SHOW_A) ? SHOW_B : SHOW_A;
            select_n  = !select;
            tgl_cnt_n = tgl_inc;
          end
        end
      end

      default: begin
        state_n  = IDLE;
        select_n = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_seg_alt_sequencer.sv
module tb_seg_alt_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       pause;
  logic       select, busy, done, tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_alt_sequencer #(
    .CNT_W       (4),
    .HALF_PERIOD (4),
    .NUM_TOGGLES (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
`ifdef SEG_ALT_PAUSE_EN
    .pause  (pause),
`endif
    .select (select),
    .busy   (busy),
    .done   (done),
    .tick   (tick)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b11; start = 1'b1; pause = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({select, busy, done, tick} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got={sel,busy,done,tick}=%b exp=0000", i, {select, busy, done, tick});
      end
    end
    rst = 1'b0; start = 1'b0;
    step();
    checks++;
    if ({select, busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_no_launch got={sel,busy}=%b exp=00", {select, busy});
    end
  endtask

  task automatic test_hold();
    mode = 2'b01; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({select, busy} !== 2'b10) begin
      failures++;
      $display("FAIL hold_b got={sel,busy}=%b exp=10", {select, busy});
    end
    mode = 2'b00; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({select, busy} !== 2'b00) begin
      failures++;
      $display("FAIL hold_a got={sel,busy}=%b exp=00", {select, busy});
    end
    // Alternate mode without start: select keeps its last hold value.
    mode = 2'b01;
    step();
    mode = 2'b10;
    step();
    step();
    checks++;
    if ({select, busy, tick} !== 3'b100) begin
      failures++;
      $display("FAIL hold_alt_nostart got={sel,busy,tick}=%b exp=100", {select, busy, tick});
    end
    mode = 2'b00;
    step();
  endtask

  task automatic test_burst();
    int  ticks;
    logic [3:0] exp;
    ticks = 0;
    mode = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 13; k++) begin
      exp = {(k >= 4 && k < 8), (k < 12), (k == 12), (k == 4 || k == 8 || k == 12)};
      if (tick === 1'b1) ticks++;
      checks++;
      if ({select, busy, done, tick} !== exp) begin
        failures++;
        $display("FAIL burst k=%0d got={sel,busy,done,tick}=%b exp=%b", k, {select, busy, done, tick}, exp);
      end
      step();
    end
    checks++;
    if (ticks != 3) begin
      failures++;
      $display("FAIL burst_tick_count got=%0d exp=3", ticks);
    end
  endtask

  task automatic test_continuous_abort();
    logic [3:0] exp;
    mode = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      exp = {((k / 4) % 2 == 1), 1'b1, 1'b0, (k > 0 && k % 4 == 0)};
      checks++;
      if ({select, busy, done, tick} !== exp) begin
        failures++;
        $display("FAIL cont k=%0d got={sel,busy,done,tick}=%b exp=%b", k, {select, busy, done, tick}, exp);
      end
      if (k < 19) step();
    end
    mode = 2'b01;
    step();
    checks++;
    if ({select, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL abort got={sel,busy,done}=%b exp=100", {select, busy, done});
    end
    mode = 2'b00;
    step();
  endtask

  task automatic test_start_mid_burst();
    mode = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({select, busy} !== 2'b11) begin
      failures++;
      $display("FAIL restart_ignored k=7 got={sel,busy}=%b exp=11", {select, busy});
    end
    for (int k = 8; k <= 11; k++) step();
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL restart_k11 got={busy,done}=%b exp=10", {busy, done});
    end
    step();
    checks++;
    if ({select, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL restart_done_k12 got={sel,busy,done}=%b exp=001", {select, busy, done});
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    mode = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    checks++;
    if ({select, busy} !== 2'b11) begin
      failures++;
      $display("FAIL midrst_pre got={sel,busy}=%b exp=11", {select, busy});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({select, busy, done, tick} !== 4'b0000) begin
      failures++;
      $display("FAIL midrst got={sel,busy,done,tick}=%b exp=0000", {select, busy, done, tick});
    end
    for (int k = 0; k < 6; k++) step();
    checks++;
    if ({select, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_stays_idle got={sel,busy,done}=%b exp=000", {select, busy, done});
    end
  endtask

  task automatic test_switch_to_burst();
    mode = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    // Toggles at k=4,8,12,16 saturate the count; switch at k=17.
    for (int k = 1; k <= 17; k++) step();
    mode = 2'b11;
    step();
    step();
    checks++;
    if ({select, busy, done} !== 3'b010) begin
      failures++;
      $display("FAIL switch_k19 got={sel,busy,done}=%b exp=010", {select, busy, done});
    end
    step();
    checks++;
    if ({select, busy, done, tick} !== 4'b0011) begin
      failures++;
      $display("FAIL switch_done_k20 got={sel,busy,done,tick}=%b exp=0011", {select, busy, done, tick});
    end
    step();
  endtask

`ifdef SEG_ALT_PAUSE_EN
  task automatic test_pause();
    mode = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    pause = 1'b1;
    for (int k = 5; k <= 9; k++) step();
    pause = 1'b0;
    checks++;
    if ({select, busy} !== 2'b11) begin
      failures++;
      $display("FAIL pause_hold k=10 got={sel,busy}=%b exp=11", {select, busy});
    end
    for (int k = 11; k <= 12; k++) step();
    checks++;
    if ({select, tick} !== 2'b10) begin
      failures++;
      $display("FAIL pause_k12 got={sel,tick}=%b exp=10", {select, tick});
    end
    for (int k = 13; k <= 16; k++) step();
    checks++;
    if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL pause_k16 got={busy,done}=%b exp=10", {busy, done});
    end
    step();
    checks++;
    if ({select, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL pause_done_k17 got={sel,busy,done}=%b exp=001", {select, busy, done});
    end
    step();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; pause = 1'b0;
    step();
    test_reset();
    test_hold();
    test_burst();
    test_continuous_abort();
    test_start_mid_burst();
    test_reset_mid_run();
    test_switch_to_burst();
`ifdef SEG_ALT_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
